// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Definitions shared by the 2-to-4 line decoder and the sequential 4-to-2
// encoder. Both blocks read the line-to-code mapping from here, so the two
// directions cannot drift apart.
//   CODE_Y3..CODE_Y0 : 2-bit code {w1,w0} assigned to each request line
//   state_e          : handshake FSM states of the encoder
//   popcount4        : number of set bits in a 4-bit vector (0..4)
// -----------------------------------------------------------------------------
package decoder_pkg;

   localparam logic [1:0] CODE_Y3 = 2'b00;
   localparam logic [1:0] CODE_Y2 = 2'b01;
   localparam logic [1:0] CODE_Y1 = 2'b10;
   localparam logic [1:0] CODE_Y0 = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,   // nothing pending, ready to capture a vector
      EMIT = 1'b1    // draining pending lines, one code per handshake
   } state_e;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/prio_pick4.sv
// -----------------------------------------------------------------------------
// prio_pick4
// Combinational priority picker. Selects the highest-priority set bit of the
// pending vector and returns its code together with a one-hot mask that
// clears exactly that bit.
//   PRIORITY_HIGH : 1 = y3 first (bit 3 down to bit 0), 0 = y0 first
//   pend_i        : pending request lines, bit3=y3 .. bit0=y0
//   code_o        : {w1,w0} code of the selected line (CODE_Y3 when none set)
//   clr_mask_o    : one-hot mask of the selected line (zero when none set)
// -----------------------------------------------------------------------------
module prio_pick4
   import decoder_pkg::*;
#(
   parameter bit PRIORITY_HIGH = 1'b1
) (
   input  logic [3:0] pend_i,
   output logic [1:0] code_o,
   output logic [3:0] clr_mask_o
);

   always_comb begin
      // NOTE: every output gets a value before any branch, so no path through
      // this block leaves an output unassigned and no latch is inferred.
      code_o     = CODE_Y3;
      clr_mask_o = 4'b0000;

      if (PRIORITY_HIGH) begin
         if (pend_i[3]) begin
            code_o     = CODE_Y3;
            clr_mask_o = 4'b1000;
         end else if (pend_i[2]) begin
            code_o     = CODE_Y2;
            clr_mask_o = 4'b0100;
         end else if (pend_i[1]) begin
            code_o     = CODE_Y1;
            clr_mask_o = 4'b0010;
         end else if (pend_i[0]) begin
            code_o     = CODE_Y0;
            clr_mask_o = 4'b0001;
         end
      end else begin
         if (pend_i[0]) begin
            code_o     = CODE_Y0;
            clr_mask_o = 4'b0001;
         end else if (pend_i[1]) begin
            code_o     = CODE_Y1;
            clr_mask_o = 4'b0010;
         end else if (pend_i[2]) begin
            code_o     = CODE_Y2;
            clr_mask_o = 4'b0100;
         end else if (pend_i[3]) begin
            code_o     = CODE_Y3;
            clr_mask_o = 4'b1000;
         end
      end
   end

endmodule

// File: rtl/four_to_two_encoder_seq.sv
// -----------------------------------------------------------------------------
// four_to_two_encoder_seq
// Sequential 4-to-2 encoder, the return path of the 2-to-4 line decoder.
// Captures a 4-bit request vector, then emits the code of every set line,
// one per out_valid/out_ready handshake, in priority order.
//   clk, rst_n       : clock, asynchronous active-low reset
//   en               : global enable; low freezes state and blocks handshakes
//   y_in, in_valid   : request vector and its valid strobe
//   in_ready         : vector can be captured (IDLE, enabled, out of reset)
//   w1, w0           : code of the current line, 00 whenever out_valid=0
//   out_valid        : w1/w0 carry a valid code
//   out_ready        : consumer accepts the current code
//   pend_cnt         : number of captured lines not yet emitted
//   zero_err         : one-cycle pulse after an all-zero vector is captured
// -----------------------------------------------------------------------------
module four_to_two_encoder_seq
   import decoder_pkg::*;
#(
   parameter bit PRIORITY_HIGH = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] y_in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       w1,
   output logic       w0,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] pend_cnt,
   output logic       zero_err
);

   state_e     state_q, state_d;
   logic [3:0] pend_q, pend_d;
   logic [2:0] cnt_q, cnt_d;
   logic       zero_err_q, zero_err_d;

   logic [1:0] pick_code;
   logic [3:0] pick_mask;
   logic [3:0] pend_left;
   logic       fire_in;
   logic       fire_out;

   prio_pick4 #(
      .PRIORITY_HIGH (PRIORITY_HIGH)
   ) u_pick (
      .pend_i     (pend_q),
      .code_o     (pick_code),
      .clr_mask_o (pick_mask)
   );

   // rst_n gates in_ready so the producer never sees a ready block while the
   // reset is still held.
   assign in_ready  = rst_n && en && (state_q == IDLE);
   assign out_valid = en && (state_q == EMIT);
   assign {w1, w0}  = out_valid ? pick_code : 2'b00;
   assign pend_cnt  = cnt_q;
   assign zero_err  = zero_err_q;

   assign fire_in   = in_valid && in_ready;
   assign fire_out  = out_valid && out_ready;
   assign pend_left = pend_q & ~pick_mask;

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      cnt_d      = cnt_q;
      zero_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (fire_in) begin
               pend_d = y_in;
               cnt_d  = popcount4(y_in);
               if (y_in != 4'b0000) begin
                  state_d = EMIT;
               end else begin
                  zero_err_d = 1'b1;
               end
            end
         end
         EMIT: begin
            if (fire_out) begin
               pend_d = pend_left;
               cnt_d  = cnt_q - 3'd1;
               // Leaving on the last handshake gives the one-cycle turnaround:
               // in_ready rises the cycle after the final code is taken.
               if (pend_left == 4'b0000) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pend_q     <= 4'b0000;
         cnt_q      <= 3'd0;
         zero_err_q <= 1'b0;
      end else begin
         // NOTE: registers use non-blocking assignments so every flop samples
         // the pre-edge value of every other flop, independent of order.
         state_q    <= state_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         zero_err_q <= zero_err_d;
      end
   end

endmodule
